// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: receiver state encoding, frame constants
// and the bit-timing helpers used by both the receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    // Clocks per bit; integer division, caller must keep the result >= 4.
    function automatic int calc_cpb(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

    // Clocks from start edge to mid start bit.
    function automatic int calc_half(input int clk_freq_hz, input int baud_rate);
        return calc_cpb(clk_freq_hz, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Holding-register handshake between the UART receiver and the IO page.
interface uart_rx_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to line idle.
module uart_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic rx_async,
    output logic rx_sync
);

    logic [1:0] sync_reg;

    // Shift the raw pin through two flops; both preset to idle-high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_async};
        end
    end

    assign rx_sync = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-byte holding register,
// sticky frame-error and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 1_000_000
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      i_uart_rx,
    uart_rx_if.master bus,
    output logic      o_frame_err,
    output logic      o_overrun,
    input  logic      i_clr_err,
    output logic      o_busy
);

    localparam int CPB  = calc_cpb(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF = calc_half(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW   = $clog2(CPB);

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic            rx_s;
    rx_state_t       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bitidx_reg, bitidx_next;
    logic [7:0]      shift_reg, shift_next;
    logic            brk_reg, brk_next;
    logic [7:0]      data_reg, data_next;
    logic            valid_reg, valid_next;
    logic            ferr_reg, ferr_next;
    logic            ovr_reg, ovr_next;
    logic            deliver;
    logic            frame_set;
    logic            ovr_set;

    uart_sync2 u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .rx_async (i_uart_rx),
        .rx_sync  (rx_s)
    );

    // Register all receiver state; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bitidx_reg <= '0;
            shift_reg  <= '0;
            brk_reg    <= 1'b0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            ferr_reg   <= 1'b0;
            ovr_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bitidx_reg <= bitidx_next;
            shift_reg  <= shift_next;
            brk_reg    <= brk_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            ferr_reg   <= ferr_next;
            ovr_reg    <= ovr_next;
        end
    end

    // Next-state, bit timing, holding register and sticky flag logic.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bitidx_next = bitidx_reg;
        shift_next  = shift_reg;
        brk_next    = brk_reg;
        data_next   = data_reg;
        valid_next  = valid_reg;
        ferr_next   = ferr_reg;
        ovr_next    = ovr_reg;
        deliver     = 1'b0;
        frame_set   = 1'b0;
        ovr_set     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next  = DATA;
                        bitidx_next = '0;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    shift_next  = {rx_s, shift_reg[7:1]};
                    cnt_next    = '0;
                    bitidx_next = bitidx_reg + 3'd1;
                    if (bitidx_reg == BIT_LAST) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STOP: begin
                if (brk_reg) begin
                    // Waiting out a break; only a high line releases us.
                    if (rx_s) begin
                        state_next = IDLE;
                        brk_next   = 1'b0;
                        cnt_next   = '0;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    if (rx_s == STOP_LEVEL) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        frame_set = 1'b1;
                        brk_next  = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (deliver) begin
            if (!valid_reg || bus.i_ready) begin
                data_next  = shift_reg;
                valid_next = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_reg && bus.i_ready) begin
            valid_next = 1'b0;
        end

        // Clear first so a coincident set event wins.
        if (i_clr_err) begin
            ferr_next = 1'b0;
            ovr_next  = 1'b0;
        end
        if (frame_set) ferr_next = 1'b1;
        if (ovr_set)   ovr_next  = 1'b1;
    end

    assign bus.o_data  = data_reg;
    assign bus.o_valid = valid_reg;
    assign o_frame_err = ferr_reg;
    assign o_overrun   = ovr_reg;
    assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at default 10 MHz / 1 Mbaud.
module tb_uart_rx;

    localparam int CLK_HZ = 10_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int CPB_T  = CLK_HZ / BAUD;
    localparam int HALF_T = CPB_T / 2;
    // Start edge -> 2 sync cycles -> mid start bit -> 8 data + 1 stop bit.
    localparam int LAT    = 2 + HALF_T + 9 * CPB_T;

    logic clk = 1'b0;
    logic resetn;
    logic i_uart_rx;
    logic o_frame_err, o_overrun, i_clr_err, o_busy;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ep_cyc;

    uart_rx_if rx_if ();

    uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_uart_rx   (i_uart_rx),
        .bus         (rx_if.master),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .i_clr_err   (i_clr_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame starting at the current negedge; stop_low bit times of
    // low line are inserted before the stop bit to model a framing error/break.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        ep_cyc = cyc + 1;
        i_uart_rx = 1'b0;
        repeat (CPB_T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            repeat (CPB_T) @(negedge clk);
        end
        if (stop_low > 0) begin
            i_uart_rx = 1'b0;
            repeat (stop_low * CPB_T) @(negedge clk);
        end
        i_uart_rx = 1'b1;
        repeat (CPB_T) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int rise, output logic ok);
        ok = 1'b0;
        rise = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_if.o_valid) begin
                rise = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_ready();
        rx_if.i_ready = 1'b1;
        @(negedge clk);
        rx_if.i_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
    endtask

    initial begin
        int         rise, rise0, rise1, busy_cnt, gap;
        logic       ok, ok0, ok1;
        logic [7:0] got0, got1, b;
        logic [7:0] exp_q[$];

        resetn = 1'b0;
        i_uart_rx = 1'b1;
        rx_if.i_ready = 1'b0;
        i_clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(rx_if.o_data), 0);
        check("rst_valid", 32'(rx_if.o_valid), 0);
        check("rst_ferr",  32'(o_frame_err), 0);
        check("rst_ovr",   32'(o_overrun), 0);
        check("rst_busy",  32'(o_busy), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame, exact latency.
        fork
            send_frame(8'h55, 0);
            wait_valid(200, rise, ok);
        join
        $display("[TB] frame 0x55 rx 0x%02h at +%0d", rx_if.o_data, rise - ep_cyc);
        check("t1_seen",  32'(ok), 1);
        check("t1_lat",   32'(rise - ep_cyc), 32'(LAT));
        check("t1_data",  32'(rx_if.o_data), 32'h55);
        check("t1_ferr",  32'(o_frame_err), 0);
        check("t1_ovr",   32'(o_overrun), 0);
        pulse_ready();
        check("t1_cons_valid", 32'(rx_if.o_valid), 0);
        check("t1_cons_data",  32'(rx_if.o_data), 32'h55);

        // Back-to-back frames, consumer reads on each valid rise.
        fork
            begin
                send_frame(8'hA5, 0);
                send_frame(8'h3C, 0);
            end
            begin
                wait_valid(250, rise0, ok0);
                got0 = rx_if.o_data;
                pulse_ready();
                wait_valid(250, rise1, ok1);
                got1 = rx_if.o_data;
                pulse_ready();
            end
        join
        $display("[TB] b2b rx 0x%02h 0x%02h", got0, got1);
        check("t2_seen0", 32'(ok0), 1);
        check("t2_seen1", 32'(ok1), 1);
        check("t2_data0", 32'(got0), 32'hA5);
        check("t2_data1", 32'(got1), 32'h3C);
        check("t2_lat1",  32'(rise1 - ep_cyc), 32'(LAT));
        check("t2_ferr",  32'(o_frame_err), 0);
        check("t2_ovr",   32'(o_overrun), 0);

        // Three-cycle glitch: START held until mid start bit, then back to IDLE.
        busy_cnt = 0;
        i_uart_rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 2) i_uart_rx = 1'b1;
            busy_cnt += int'(o_busy);
        end
        $display("[TB] glitch busy for %0d cycles", busy_cnt);
        check("t3_busy_cnt", 32'(busy_cnt), 32'(HALF_T));
        check("t3_valid", 32'(rx_if.o_valid), 0);
        check("t3_ferr",  32'(o_frame_err), 0);
        check("t3_ovr",   32'(o_overrun), 0);

        // Stop bit low for two bit times: frame error, busy until line high.
        fork
            send_frame(8'h81, 2);
            begin
                repeat (LAT + 8) @(negedge clk);
                check("t4_busy_brk", 32'(o_busy), 1);
                check("t4_ferr_brk", 32'(o_frame_err), 1);
                check("t4_valid",    32'(rx_if.o_valid), 0);
            end
        join
        $display("[TB] frame 0x81 with break, ferr=%0d", o_frame_err);
        check("t4_busy_end", 32'(o_busy), 0);
        check("t4_ferr_end", 32'(o_frame_err), 1);
        check("t4_valid_end", 32'(rx_if.o_valid), 0);
        pulse_clr();
        check("t4_ferr_clr", 32'(o_frame_err), 0);

        // Overrun: second byte dropped while the first is still held.
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
        $display("[TB] overrun pair rx 0x%02h ovr=%0d", rx_if.o_data, o_overrun);
        check("t5_valid", 32'(rx_if.o_valid), 1);
        check("t5_data",  32'(rx_if.o_data), 32'h11);
        check("t5_ovr",   32'(o_overrun), 1);
        check("t5_ferr",  32'(o_frame_err), 0);
        pulse_ready();
        check("t5_cons_valid", 32'(rx_if.o_valid), 0);
        repeat (150) @(negedge clk);
        check("t5_no_second", 32'(rx_if.o_valid), 0);
        pulse_clr();
        check("t5_ovr_clr", 32'(o_overrun), 0);

        // Read on the very edge of the stop sample: old byte out, new byte in.
        send_frame(8'h44, 0);
        fork
            send_frame(8'h33, 0);
            begin
                repeat (LAT) @(negedge clk);
                pulse_ready();
                $display("[TB] same-edge read, holding now 0x%02h", rx_if.o_data);
                check("t5b_valid", 32'(rx_if.o_valid), 1);
                check("t5b_data",  32'(rx_if.o_data), 32'h33);
                check("t5b_ovr",   32'(o_overrun), 0);
            end
        join
        pulse_ready();

        // Reset during bit 4 of 0xF0, then a clean 0x0F.
        fork
            send_frame(8'hF0, 0);
            begin
                repeat (5 * CPB_T + HALF_T) @(negedge clk);
                resetn = 1'b0;
                #1;
                check("t6_rst_data",  32'(rx_if.o_data), 0);
                check("t6_rst_valid", 32'(rx_if.o_valid), 0);
                check("t6_rst_ferr",  32'(o_frame_err), 0);
                check("t6_rst_ovr",   32'(o_overrun), 0);
                check("t6_rst_busy",  32'(o_busy), 0);
                repeat (10) @(negedge clk);
                resetn = 1'b1;
            end
        join
        check("t6_abandoned", 32'(rx_if.o_valid), 0);
        fork
            send_frame(8'h0F, 0);
            wait_valid(200, rise, ok);
        join
        $display("[TB] post-reset frame rx 0x%02h", rx_if.o_data);
        check("t6_seen", 32'(ok), 1);
        check("t6_data", 32'(rx_if.o_data), 32'h0F);
        check("t6_lat",  32'(rise - ep_cyc), 32'(LAT));
        pulse_ready();

        // Random bytes with random idle gaps against the expected-byte queue.
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            gap = int'($urandom_range(0, 15));
            repeat (gap) @(negedge clk);
            exp_q.push_back(b);
            fork
                send_frame(b, 0);
                wait_valid(200, rise, ok);
            join
            $display("[TB] random frame 0x%02h rx 0x%02h at +%0d", b, rx_if.o_data, rise - ep_cyc);
            check("rnd_seen", 32'(ok), 1);
            check("rnd_lat",  32'(rise - ep_cyc), 32'(LAT));
            check("rnd_data", 32'(rx_if.o_data), 32'(exp_q.pop_front()));
            pulse_ready();
        end
        check("rnd_flags", {30'd0, o_frame_err, o_overrun}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that pairs with the SoC's UART transmitter, on the same clk/resetn domain and baud configuration.
- Samples the asynchronous RX pin, reassembles bytes LSB-first and holds one received byte for the CPU IO page.
- The IO page reads o_data/o_valid and pulses i_ready on read. Line errors are reported through sticky flags.

Parameters:
CLK_FREQ_HZ, 10000000, system clock frequency in Hz
BAUD_RATE, 1000000, line bit rate in baud
(derived, not overridable) CPB = CLK_FREQ_HZ/BAUD_RATE, integer division, must be >= 4; HALF = CPB/2

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
i_uart_rx  input  1  serial line, idle high, asynchronous to clk
o_data  output  8  last received byte, valid while o_valid=1
o_valid  output  1  holding register full
i_ready  input  1  consumer takes byte when o_valid&i_ready at a rising edge
o_frame_err  output  1  sticky: stop bit sampled low
o_overrun  output  1  sticky: byte completed while holding register still full
i_clr_err  input  1  synchronous clear of both sticky flags
o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, resetn=0):
  - Sync flops are 1; FSM goes to IDLE; counters, shift register and o_data are 0.
  - o_valid, o_frame_err, o_overrun and o_busy are 0.
  - Reset mid-frame abandons the frame; no byte is delivered.
- Synchronizer: i_uart_rx passes through two flops to give rx_s. This adds 2 cycles of latency. No other logic touches the raw pin.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt counts up each cycle.
  - At cnt==HALF-1: if rx_s==0 -> DATA, cnt=0, bitidx=0; otherwise this is a glitch -> IDLE, nothing reported.
- DATA:
  - At cnt==CPB-1: shift = {rx_s, shift[7:1]}, cnt=0, bitidx++.
  - After the 8th sample -> STOP.
- STOP:
  - At cnt==CPB-1, sample rx_s.
  - rx_s==1 -> deliver the byte, go to IDLE.
  - rx_s==0 -> set o_frame_err, discard the byte, stay in STOP (cnt held) until rx_s==1, then go to IDLE. A break condition does not retrigger reception.
- Delivery, evaluated on the edge of the stop sample:
  - o_valid==0 -> o_data=shift, o_valid=1.
  - o_valid==1 and i_ready==1 on the same edge -> the old byte is consumed, the new byte is loaded, o_valid stays 1, no overrun.
  - o_valid==1 and i_ready==0 -> the new byte is dropped, o_data is unchanged, o_overrun=1.
- Consume: o_valid&i_ready with no delivery on that edge -> o_valid=0. o_data retains its value.
- Sticky flags:
  - i_clr_err=1 clears both flags.
  - If a set event and i_clr_err coincide, the set wins.
- Latency, with Ep = the first edge sampling the pin low:
  - Stop sample is at Ep+2+HALF+9*CPB; o_valid is high after that edge.
  - For default parameters this is Ep+97.
- Back-to-back frames: the FSM is in IDLE one cycle after a good stop sample, i.e. mid stop bit. The next start edge is therefore caught with no gap.
- Widths:
  - cnt is $clog2(CPB) bits; it never exceeds CPB-1 and wraps to 0 on each sample.
  - bitidx is 3 bits plus terminal detect.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP, 2 bits);
  - the function computing CPB/HALF from the two parameters;
  - the 8N1 constants (DATA_BITS=8, STOP_LEVEL=1).
- The package is shared with the transmitter side.
- One sub-module: uart_sync2, a 2-flop synchronizer with an async reset-to-1 value. Everything else lives in uart_rx.

Test Plan:
- Send 0x55 at 1 Mbaud after reset -> o_valid rises at Ep+97 (±0), o_data=0x55, o_frame_err=0, o_overrun=0.
- Send 0xA5 then 0x3C with no idle gap; i_ready pulsed when each o_valid rises -> two deliveries, 0xA5 then 0x3C, no flags.
- Pulse i_uart_rx low for 3 cycles only -> o_busy high for ~5 cycles, then IDLE; no o_valid, no flags.
- Send 0x81 with the stop bit forced low for 2 bit times -> o_frame_err=1, o_valid=0; o_busy stays high until the line returns high; i_clr_err then clears the flag.
- Send 0x11 then 0x22 with i_ready=0 throughout -> o_data=0x11, o_overrun=1. A later i_ready yields 0x11 only.
- Assert resetn=0 during bit 4 of 0xF0, release, send 0x0F -> only 0x0F is delivered; all outputs read 0 during reset.
